// File: rtl/mem_cpu_core_if.sv
// Bus bundle for mem_cpu_core: the single-port synchronous memory port, the OUT
// stream and the retire/halt status lines.
interface mem_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              instr_done;
    logic              halted;

    // OUT stream: a word transfers at a rising edge with out_valid && out_ready; once
    // raised, out_valid and out_data hold until that edge, and out_ready is ignored while out_valid=0.
    modport master (
        output mem_addr, mem_rd, mem_wr, mem_wdata,
        input  mem_rdata,
        output out_data, out_valid,
        input  out_ready,
        output instr_done, halted
    );

    modport slave (
        input  mem_addr, mem_rd, mem_wr, mem_wdata,
        output mem_rdata,
        input  out_data, out_valid,
        output out_ready,
        input  instr_done, halted
    );
endinterface

// File: rtl/mem_cpu_core.sv
// Memory-to-memory toy CPU: one-word opcode and operand fields fetched from an
// external synchronous RAM (2-cycle reads, 1-cycle writes), OUT via valid/ready.
module mem_cpu_core #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_cpu_core_if.master bus,
    output logic [2:0]     dbg_state
);
    typedef enum logic [2:0] {
        S_FETCH, S_OPER, S_LOAD_A, S_LOAD_B, S_WRITE, S_OUT_WAIT, S_HALT
    } state_t;

    localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(0);
    localparam logic [DATA_W-1:0] OP_SUB  = DATA_W'(1);
    localparam logic [DATA_W-1:0] OP_JMP  = DATA_W'(3);
    localparam logic [DATA_W-1:0] OP_JZ   = DATA_W'(4);
    localparam logic [DATA_W-1:0] OP_OUT  = DATA_W'(5);
    localparam logic [DATA_W-1:0] OP_SET  = DATA_W'(6);
    localparam logic [DATA_W-1:0] OP_HALT = DATA_W'(7);

    function automatic logic [1:0] nfields(input logic [DATA_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB: return 2'd3;
            OP_JZ, OP_SET:  return 2'd2;
            OP_JMP, OP_OUT: return 2'd1;
            default:        return 2'd0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] to_addr(input logic [DATA_W-1:0] w);
        return ADDR_W'(w);
    endfunction

    state_t            state_q, state_d;
    logic              ph_q, ph_d;  // 0: read issue cycle, 1: capture cycle
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] op_q, op_d;
    logic [1:0]        fidx_q, fidx_d;
    logic [DATA_W-1:0] fld_q [3];
    logic [DATA_W-1:0] fld_d [3];
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;

    logic              rd, wr, done;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              arith;

    assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        pc_d    = pc_q;
        op_d    = op_q;
        fidx_d  = fidx_q;
        fld_d   = fld_q;
        a_d     = a_q;
        b_d     = b_q;
        rd      = 1'b0;
        wr      = 1'b0;
        done    = 1'b0;
        addr    = '0;
        wdata   = '0;
        case (state_q)
            S_FETCH: begin
                addr = pc_q;
                rd   = !ph_q;
                ph_d = !ph_q;
                if (ph_q) begin
                    pc_d   = pc_q + ADDR_W'(1);
                    op_d   = bus.mem_rdata;
                    fidx_d = '0;
                    if (bus.mem_rdata == OP_HALT) begin
                        done    = 1'b1;
                        state_d = S_HALT;
                    end else if (nfields(bus.mem_rdata) != 2'd0) begin
                        state_d = S_OPER;
                    end else begin
                        done = 1'b1;
                    end
                end
            end
            S_OPER: begin
                addr = pc_q;
                rd   = !ph_q;
                ph_d = !ph_q;
                if (ph_q) begin
                    pc_d   = pc_q + ADDR_W'(1);
                    fidx_d = fidx_q + 2'd1;
                    for (int i = 0; i < 3; i++) begin
                        if (fidx_q == 2'(i)) fld_d[i] = bus.mem_rdata;
                    end
                    if (fidx_q == nfields(op_q) - 2'd1) begin
                        if (op_q == OP_JMP) begin
                            pc_d    = to_addr(bus.mem_rdata);
                            done    = 1'b1;
                            state_d = S_FETCH;
                        end else if (op_q == OP_SET) begin
                            state_d = S_WRITE;
                        end else begin
                            state_d = S_LOAD_A;
                        end
                    end
                end
            end
            S_LOAD_A: begin
                addr = arith ? to_addr(fld_q[1]) : to_addr(fld_q[0]);
                rd   = !ph_q;
                ph_d = !ph_q;
                if (ph_q) begin
                    a_d = bus.mem_rdata;
                    if (arith) begin
                        state_d = S_LOAD_B;
                    end else if (op_q == OP_JZ) begin
                        // pc already points past both fields, which is the not-taken target
                        if (bus.mem_rdata == '0) pc_d = to_addr(fld_q[1]);
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_OUT_WAIT;
                    end
                end
            end
            S_LOAD_B: begin
                addr = to_addr(fld_q[2]);
                rd   = !ph_q;
                ph_d = !ph_q;
                if (ph_q) begin
                    b_d     = bus.mem_rdata;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                addr    = to_addr(fld_q[0]);
                wr      = 1'b1;
                wdata   = (op_q == OP_ADD) ? a_q + b_q :
                          (op_q == OP_SUB) ? a_q - b_q : fld_q[1];
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_OUT_WAIT: begin
                if (bus.out_ready) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ph_q    <= 1'b0;
            pc_q    <= RESET_PC;
            op_q    <= '0;
            fidx_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            for (int i = 0; i < 3; i++) fld_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            fidx_q  <= fidx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fld_q   <= fld_d;
        end
    end

    // Outputs are forced low while reset is asserted; fetch starts right on release.
    assign bus.mem_rd     = rd && rst_n;
    assign bus.mem_wr     = wr && rst_n;
    assign bus.mem_addr   = rst_n ? addr : '0;
    assign bus.mem_wdata  = rst_n ? wdata : '0;
    assign bus.instr_done = done && rst_n;
    assign bus.out_valid  = (state_q == S_OUT_WAIT) && rst_n;
    assign bus.out_data   = a_q;
    assign bus.halted     = (state_q == S_HALT) && rst_n;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_mem_cpu_core.sv
// Self-checking bench for mem_cpu_core: an 8-bit core (RESET_PC=0) and a 16-bit core
// (RESET_PC=0x100) run side by side, each with its own behavioural synchronous RAM.
module tb_mem_cpu_core;
  localparam logic [2:0] ST_LOAD_B = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b0;
  logic [2:0] dbg8, dbg16;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mem8  [0:4095];
  logic [15:0] mem16 [0:4095];

  always #5 clk = ~clk;

  mem_cpu_core_if #(.DATA_W(8),  .ADDR_W(12)) if8 ();
  mem_cpu_core_if #(.DATA_W(16), .ADDR_W(12)) if16 ();

  assign if8.out_ready  = out_ready;
  assign if16.out_ready = out_ready;

  mem_cpu_core #(.DATA_W(8), .ADDR_W(12), .RESET_PC(12'h000)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8), .dbg_state(dbg8));
  mem_cpu_core #(.DATA_W(16), .ADDR_W(12), .RESET_PC(12'h100)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16), .dbg_state(dbg16));

  // Behavioural single-port RAMs, 1-cycle read latency.
  always @(posedge clk) begin
    if (if8.mem_rd) if8.mem_rdata <= mem8[if8.mem_addr];
    if (if8.mem_wr) mem8[if8.mem_addr] = if8.mem_wdata;
    if (if16.mem_rd) if16.mem_rdata <= mem16[if16.mem_addr];
    if (if16.mem_wr) mem16[if16.mem_addr] = if16.mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 4096; i++) begin
      mem8[i]  = '0;
      mem16[i] = '0;
    end
  endtask

  task automatic enter_reset();
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  // Returns sampling inside cycle 1 after release.
  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  exp8;
    logic [15:0] exp16;
  } arith_vec_t;

  arith_vec_t vecs [6];
  int cd_prog [19];
  logic [7:0] exp_q [$];

  initial begin
    int d8, d16, n_out, n_late, first_valid, n_valid, n_bus, n_dchg, first_done, n_done, n_wr;
    logic [7:0] held;

    vecs[0] = '{op: 8'd0, a: 16'd200, b: 16'd100, exp8: 8'd44,  exp16: 16'd300};
    vecs[1] = '{op: 8'd1, a: 16'd3,   b: 16'd5,   exp8: 8'd254, exp16: 16'd65534};
    vecs[2] = '{op: 8'd0, a: 16'd255, b: 16'd1,   exp8: 8'd0,   exp16: 16'd256};
    vecs[3] = '{op: 8'd1, a: 16'd10,  b: 16'd10,  exp8: 8'd0,   exp16: 16'd0};
    vecs[4] = '{op: 8'd1, a: 16'd0,   b: 16'd1,   exp8: 8'd255, exp16: 16'd65535};
    vecs[5] = '{op: 8'd0, a: 16'd128, b: 16'd128, exp8: 8'd0,   exp16: 16'd256};
    cd_prog = '{6, 'hF0, 16, 6, 'hF1, 1, 5, 'hF0, 4, 'hF0, 17, 1, 'hF0, 'hF0, 'hF1, 3, 3, 3, 17};

    // Outputs held at zero during reset
    clear_mems();
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs8", {if8.mem_rd, if8.mem_wr, if8.out_valid, if8.instr_done, if8.halted}, 5'b0);
    check("reset_outputs16", {if16.mem_rd, if16.mem_wr, if16.out_valid, if16.instr_done, if16.halted}, 5'b0);

    // ADD/SUB table on both widths: op d=0x40 a=0x41 b=0x42, then HALT
    for (int v = 0; v < 6; v++) begin
      enter_reset();
      clear_mems();
      mem8[0] = vecs[v].op; mem8[1] = 8'h40; mem8[2] = 8'h41; mem8[3] = 8'h42; mem8[4] = 8'd7;
      mem8[12'h40] = 8'hEE; mem8[12'h41] = vecs[v].a[7:0]; mem8[12'h42] = vecs[v].b[7:0];
      mem16[12'h100] = 16'(vecs[v].op); mem16[12'h101] = 16'h40; mem16[12'h102] = 16'h41;
      mem16[12'h103] = 16'h42; mem16[12'h104] = 16'd7;
      mem16[12'h40] = 16'hEEEE; mem16[12'h41] = vecs[v].a; mem16[12'h42] = vecs[v].b;
      release_reset();
      d8 = 0; d16 = 0;
      for (int c = 1; c <= 30; c++) begin
        if (c > 1) next_cycle();
        if (if8.instr_done && d8 == 0) d8 = c;
        if (if16.instr_done && d16 == 0) d16 = c;
      end
      check($sformatf("arith%0d_result8", v), 32'(mem8[12'h40]), 32'(vecs[v].exp8));
      check($sformatf("arith%0d_result16", v), 32'(mem16[12'h40]), 32'(vecs[v].exp16));
      check($sformatf("arith%0d_retire_cycle", v), 32'(d8), 32'd13);
      check($sformatf("arith%0d_halted", v), {31'b0, if8.halted & if16.halted}, 32'd1);
    end

    // Countdown with out_ready tied high
    enter_reset();
    clear_mems();
    for (int i = 0; i < 19; i++) mem8[i] = 8'(cd_prog[i]);
    for (int k = 16; k >= 0; k--) exp_q.push_back(8'(k));
    out_ready = 1'b1;
    release_reset();
    n_out = 0; n_late = 0;
    for (int c = 1; c <= 1200; c++) begin
      if (c > 1) next_cycle();
      if (if8.out_valid) begin
        n_out++;
        if (c > 700) n_late++;
        if (exp_q.size() != 0) check("countdown_value", 32'(if8.out_data), 32'(exp_q.pop_front()));
      end
    end
    check("countdown_count", 32'(n_out), 32'd17);
    check("countdown_quiet_after_end", 32'(n_late), 32'd0);
    check("countdown_not_halted", {31'b0, if8.halted}, 32'd0);

    // OUT stalled by out_ready low for 5 cycles, accepted in the 6th
    enter_reset();
    clear_mems();
    mem8[0] = 8'd5; mem8[1] = 8'h40; mem8[2] = 8'd7; mem8[12'h40] = 8'h5A;
    release_reset();
    first_valid = 0; n_valid = 0; n_bus = 0; n_dchg = 0; first_done = 0; n_done = 0; held = '0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin
        @(negedge clk);
        out_ready = (c == 12);
        #1;
      end
      if (if8.out_valid) begin
        if (first_valid == 0) begin first_valid = c; held = if8.out_data; end
        else if (if8.out_data !== held) n_dchg++;
        n_valid++;
        if (if8.mem_rd || if8.mem_wr) n_bus++;
      end
      if (if8.instr_done) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
    end
    check("out_first_valid_cycle", 32'(first_valid), 32'd7);
    check("out_valid_cycles", 32'(n_valid), 32'd6);
    check("out_data", 32'(held), 32'h5A);
    check("out_data_changes", 32'(n_dchg), 32'd0);
    check("out_wait_bus_activity", 32'(n_bus), 32'd0);
    check("out_retire_cycle", 32'(first_done), 32'd12);
    check("out_done_count", 32'(n_done), 32'd2);

    // Reset asserted during LOAD_B of an ADD abandons it
    enter_reset();
    clear_mems();
    mem8[0] = 8'd0; mem8[1] = 8'h40; mem8[2] = 8'h41; mem8[3] = 8'h42; mem8[12'h40] = 8'h77;
    mem16[12'h100] = 16'd0; mem16[12'h101] = 16'h40; mem16[12'h102] = 16'h41;
    mem16[12'h103] = 16'h42; mem16[12'h40] = 16'h77;
    release_reset();
    n_wr = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) next_cycle();
      if (if8.mem_wr || if16.mem_wr) n_wr++;
    end
    check("abort_in_load_b8", 32'(dbg8), 32'(ST_LOAD_B));
    check("abort_in_load_b16", 32'(dbg16), 32'(ST_LOAD_B));
    rst_n = 1'b0;
    #1;
    check("abort_outputs_low", {30'b0, if8.mem_rd, if16.mem_rd}, 32'd0);
    @(negedge clk);
    mem8[0] = 8'd7;
    mem16[12'h100] = 16'd7;
    release_reset();
    check("post_reset_fetch8", {19'b0, if8.mem_rd, if8.mem_addr}, {19'b0, 1'b1, 12'h000});
    check("post_reset_fetch16", {19'b0, if16.mem_rd, if16.mem_addr}, {19'b0, 1'b1, 12'h100});
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) next_cycle();
      if (if8.mem_wr || if16.mem_wr) n_wr++;
    end
    check("abort_no_write", 32'(n_wr), 32'd0);
    check("abort_mem8_untouched", 32'(mem8[12'h40]), 32'h77);
    check("abort_mem16_untouched", 32'(mem16[12'h40]), 32'h77);

    // NOP at the top address wraps the next fetch to 0 (16-bit core)
    enter_reset();
    clear_mems();
    mem16[12'h100] = 16'd3; mem16[12'h101] = 16'h0FFF; mem16[12'hFFF] = 16'd9; mem16[0] = 16'd7;
    release_reset();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) next_cycle();
      if (c == 5) check("nop_fetch_top", {19'b0, if16.mem_rd, if16.mem_addr}, {19'b0, 1'b1, 12'hFFF});
      if (c == 7) check("nop_wrap_fetch0", {19'b0, if16.mem_rd, if16.mem_addr}, {19'b0, 1'b1, 12'h000});
      if (c == 9) check("nop_wrap_halted", {31'b0, if16.halted}, 32'd1);
    end

    // JMP at the top address with its target field wrapped to address 0
    enter_reset();
    clear_mems();
    mem16[12'h100] = 16'd3; mem16[12'h101] = 16'h0FFF; mem16[12'hFFF] = 16'd3;
    mem16[0] = 16'h0123; mem16[12'h123] = 16'd7;
    release_reset();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) next_cycle();
      if (c == 7) check("jmp_field_wrap", {19'b0, if16.mem_rd, if16.mem_addr}, {19'b0, 1'b1, 12'h000});
      if (c == 9) check("jmp_target_fetch", {19'b0, if16.mem_rd, if16.mem_addr}, {19'b0, 1'b1, 12'h123});
      if (c == 11) check("jmp_wrap_halted", {31'b0, if16.halted}, 32'd1);
    end

    // HALT retires in 2 cycles and is then inert
    enter_reset();
    clear_mems();
    mem8[0] = 8'd7;
    release_reset();
    next_cycle();
    check("halt_done_cycle2", {30'b0, if8.instr_done, if8.halted}, 32'b10);
    next_cycle();
    check("halt_halted_cycle3", {30'b0, if8.instr_done, if8.halted}, 32'b01);
    n_bus = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (if8.mem_rd || if8.mem_wr || if8.out_valid || if8.instr_done || !if8.halted) n_bus++;
    end
    check("halt_inert_50", 32'(n_bus), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_cpu_core.md
Name: mem_cpu_core

Overview:
Parametrised successor of the team's memory-to-memory toy CPU. The core executes the same one-word-per-field, memory-operand instruction set, extended with a HALT opcode. Program/data storage moves out to an external single-port synchronous memory, and the output pulse becomes a valid/ready stream. Data width, address width and reset vector are parameters.

Parameters:
DATA_W, 8, width of a memory word, operands and output data (>=4)
ADDR_W, 12, word-address width; memory depth 2^ADDR_W words
RESET_PC, 0, word address of the first fetch after reset

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
mem_addr  out  ADDR_W  word address for read or write
mem_rd  out  1  read strobe; data returned on mem_rdata, sampled at the next rising edge
mem_wr  out  1  write strobe; mem_addr/mem_wdata written at this edge
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data (1-cycle latency)
out_data  out  DATA_W  OUT instruction payload
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts when out_valid&&out_ready at a rising edge
instr_done  out  1  one-cycle pulse when an instruction retires
halted  out  1  high once HALT has retired

Behaviour:
- Reset (asynchronous on rst_n low): pc=RESET_PC, FSM=FETCH, all outputs 0. An instruction in flight is abandoned; no write or OUT occurs for it after release. The first cycle after release drives mem_rd=1, mem_addr=RESET_PC.
- Memory access: each read takes 2 cycles. In the issue cycle mem_rd=1 and mem_addr is driven. In the capture cycle mem_rd=0 and mem_rdata is registered. A write takes 1 cycle (mem_wr=1). mem_rd and mem_wr are never high together.
- Operand fields are single words. An address from a field is the low ADDR_W bits of the word, zero-extended if DATA_W<ADDR_W.
- Opcodes and their fields. pc advances past all fields, modulo 2^ADDR_W; field fetches wrap from the top address to 0.
  - 0 ADD d a b: M[d]=M[a]+M[b] mod 2^DATA_W. 13 cycles.
  - 1 SUB d a b: M[d]=M[a]-M[b] mod 2^DATA_W (borrow discarded). 13 cycles.
  - 3 JMP t: pc=t. 4 cycles.
  - 4 JZ a t: pc = t if M[a]==0, else pc+3. All fields are read either way. 8 cycles.
  - 5 OUT a: out_data=M[a], out_valid=1. 6 cycles plus wait.
  - 6 SET x v: M[x]=v. 7 cycles.
  - 7 HALT: halted=1. 2 cycles.
  - Other opcodes are NOPs: pc+1, 2 cycles.
- FSM states: FETCH, OPER(field index), LOAD_A, LOAD_B, WRITE, OUT_WAIT, HALT. The opcode selects the field count and the sequence of states. Return to FETCH follows retire.
- Operand ordering: all reads complete before the write. "SUB f0 f0 f1" and d==a==b are therefore well defined. A write into code space is visible at the next fetch.
- OUT handshake:
  - out_valid rises in the cycle after M[a] is captured.
  - out_data is stable while out_valid is high.
  - The instruction retires at the accepting edge; out_valid drops the next cycle.
  - out_ready is ignored while out_valid=0.
  - No memory access occurs during OUT_WAIT.
- instr_done pulses for one cycle at every retire, including NOP and HALT, and on the last cycle of each instruction.
- HALT state is terminal until reset: mem_rd=mem_wr=0, out_valid=0, halted=1.

Test Plan:
- Countdown program (SET f0,16; SET f1,1; OUT f0; JZ f0,e0; SUB f0,f0,f1; JMP 3; e0: JMP e0), out_ready tied 1 -> exactly 17 outputs 16,15,...,0 in order, then perpetual JMP, no further out_valid.
- OUT with out_ready low for 5 cycles -> out_valid high for 6 cycles, out_data constant, no mem_rd/mem_wr, instr_done once at acceptance.
- ADD with M[a]=200, M[b]=100, DATA_W=8 -> M[d]=44. SUB 3-5 -> 254. Rerun with DATA_W=16 -> 300 and 65534.
- rst_n pulsed low during LOAD_B of an ADD -> no mem_wr ever for that ADD; the first post-reset cycle has mem_rd=1, mem_addr=RESET_PC. Repeat with RESET_PC=0x100.
- NOP at address 2^ADDR_W-1 -> next fetch at address 0. JMP whose field lies at address 0 after wrap -> jumps correctly.
- HALT opcode -> halted=1 and instr_done pulse after 2 cycles; no mem_rd/mem_wr for 50 further cycles; out_ready toggling has no effect.
